fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the rv32i core. Holds the PC, drives the instruction
//   memory address, and captures the returned word into the IF/ID pipeline register
//   consumed by decode. Supports stall, control-flow redirect (branch, jump, trap,
//   uret) and a halt request.
// PARAMETERS
//   RESET_PC   16'h0000       PC value loaded on reset
//   IMEM_WORDS 128            words in instruction memory; fetches at or beyond are out of range
//   NOP_INSTR  32'h00000013   bubble instruction (addi x0,x0,0)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous, active-high reset
//   stall          in   1   hazard stall from decode/execute; hold PC and IF/ID
//   redirect_valid in   1   taken branch/jump/trap/uret this cycle
//   redirect_pc    in   16  target PC for redirect
//   halt_req       in   1   stop fetching (ebreak/ecall halt)
//   imem_addr      out  16  byte address to instruction memory (= pc)
//   imem_rd        in   32  instruction word, combinational from imem_addr
//   id_valid       out  1   IF/ID holds a real instruction
//   id_pc          out  16  PC of id_instr
//   id_pc_plus4    out  16  id_pc + 4, used for jal/jalr link
//   id_instr       out  32  instruction to decode (NOP_INSTR when not valid)
//   fetch_fault    out  1   registered with IF/ID: id_pc out of range (and misaligned, see CONFIGURATION)
//   halted         out  1   FSM in HALT
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0,
//     id_pc_plus4=0, fetch_fault=0, state=BOOT, halted=0.
//   FSM: BOOT -> RUN on first clk after rst deasserts (no capture in BOOT, id_valid stays 0);
//     RUN -> HALT when halt_req & ~redirect_valid; HALT -> RUN only on redirect_valid
//     (trap/uret); HALT stays otherwise. In HALT: pc holds, IF/ID loads bubble.
//   imem_addr = pc, combinational; one-cycle latency from pc to id_instr.
//   Priority per RUN cycle: redirect_valid > stall > normal.
//     redirect: pc<=redirect_pc; IF/ID<=bubble (id_valid=0, id_instr=NOP_INSTR),
//       even if stall is high (wrong-path word is squashed).
//     stall: pc and entire IF/ID hold their values.
//     normal: IF/ID<={1, pc, pc+4, imem_rd}; pc<=pc+4.
//   Arithmetic: 16-bit, pc+4 wraps 16'hFFFC -> 16'h0000, no flag.
//   Out of range (pc>>2 >= IMEM_WORDS): captured as bubble with id_valid=0, fetch_fault=1,
//     id_pc=faulting pc; pc still advances. fetch_fault clears on the next capture or bubble.
//   halt_req while stall: transition to HALT still occurs; the stalled IF/ID is replaced by a bubble.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> pc<=redirect_pc (unmodified), next
//     capture is a bubble with fetch_fault=1. Undefined: redirect_pc[1:0] forced to 2'b00.
// STRUCTURE
//   Shared header rv32_defs.vh: PC_W=16, XLEN=32, NOP_INSTR, FSM state encodings.
//   One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls); PC and FSM in top.
// TESTING
//   Reset: rst pulse mid-run -> same cycle pc=0, id_valid=0, id_instr=32'h00000013; first
//     capture on the 2nd clk after release.
//   Sequential: run 10 words -> id_pc 0,4,...,36 with id_instr=ROM[id_pc>>2], id_pc_plus4=id_pc+4.
//   Stall: stall high 3 cycles at pc=8 -> id_pc=4 and pc=8 held; resume -> id_pc=8 next.
//   Redirect+stall: redirect_pc=16'h0028 with stall=1 -> next id_valid=0; next id_pc=16'h0028.
//   Range/halt: pc=16'h01FC -> valid; pc=16'h0200 -> fetch_fault=1; halt_req -> halted=1,
//     id_valid=0 until redirect_pc=16'h0028 resumes RUN.
//   Align: redirect_pc=16'h0006 -> fault with FETCH_ALIGN_CHECK_EN, fetch from 16'h0004 without.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the rv32i fetch stage: widths, bubble word, FSM states.
package fetch_stage_pkg;

  localparam int PC_W = 16;
  localparam int XLEN = 32;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [XLEN-1:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Sequential next PC; 16-bit wrap is intentional (0xFFFC -> 0x0000).
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Three controls, in priority order:
//   bubble : squash to NOP, clear valid and fault, keep pc fields
//   load   : capture pc/pc+4 and either the word or (on fault) a faulting bubble
//   neither: hold everything (stall)
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_bubble,
  input  logic            i_load,
  input  logic            i_fault,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_instr,
  output logic            o_fault
);

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_instr;
  logic            r_fault;

  // Register update: bubble beats load; no control means hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_instr    <= BUBBLE;
      r_fault    <= 1'b0;
    end else if (i_bubble) begin
      r_valid    <= 1'b0;
      r_instr    <= BUBBLE;
      r_fault    <= 1'b0;
    end else if (i_load) begin
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_fault    <= i_fault;
      r_valid    <= ~i_fault;
      r_instr    <= i_fault ? BUBBLE : i_instr;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_instr    = r_instr;
  assign o_fault    = r_fault;

endmodule

// File: rtl/fetch_stage.sv
// rv32i instruction-fetch stage: PC, BOOT/RUN/HALT FSM, imem address and IF/ID.
// Optional build macro FETCH_ALIGN_CHECK_EN: keep misaligned redirect targets
// as-is and fault on them; otherwise redirect targets are forced word-aligned.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter int              IMEM_WORDS = 128,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr,
  output logic            fetch_fault,
  output logic            halted
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_redir_pc;
  logic            w_oor;
  logic            w_misalign;
  logic            w_fault;
  logic            w_load;
  logic            w_bubble;
  logic            w_halted;

  assign w_pc_plus4 = pc_inc(r_pc);
  assign imem_addr  = r_pc;

  // Word index compared in 32 bits so large IMEM_WORDS values cannot truncate.
  assign w_oor = (32'(r_pc[PC_W-1:2]) >= 32'(IMEM_WORDS));

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redir_pc = redirect_pc;
  assign w_misalign = (r_pc[1:0] != 2'b00);
`else
  assign w_redir_pc = redirect_pc & ~PC_W'(3);
  assign w_misalign = 1'b0;
`endif

  assign w_fault = w_oor | w_misalign;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: redirect always wins over a halt request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (!redirect_valid && halt_req) w_state_nxt = ST_HALT;
      ST_HALT: if (redirect_valid)              w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // FSM outputs: next PC and IF/ID controls.
  // Halt entry squashes whatever sits in IF/ID, even under stall.
  always_comb begin
    w_pc_nxt = r_pc;
    w_load   = 1'b0;
    w_bubble = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          w_bubble = 1'b1;
        end else if (halt_req) begin
          w_bubble = 1'b1;
        end else if (!stall) begin
          w_pc_nxt = w_pc_plus4;
          w_load   = 1'b1;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
        w_bubble = 1'b1;
        if (redirect_valid) w_pc_nxt = w_redir_pc;
      end
      default: ;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_nxt;
  end

  assign halted = w_halted;

  fetch_stage_if_id_reg #(.BUBBLE(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_bubble   (w_bubble),
    .i_load     (w_load),
    .i_fault    (w_fault),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_instr    (imem_rd),
    .o_valid    (id_valid),
    .o_pc       (id_pc),
    .o_pc_plus4 (id_pc_plus4),
    .o_instr    (id_instr),
    .o_fault    (fetch_fault)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a spec-level reference model and a
// per-cycle compare process, plus hand-computed literal checkpoints.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_req = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fetch_fault;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:127];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .fetch_fault    (fetch_fault),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: 128 words; anything beyond returns garbage that must never be captured.
  assign imem_rd = (imem_addr < 16'h0200) ? rom[imem_addr[8:2]] : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 booting, 1 running, 2 halted
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_id_pc;
  logic [15:0] m_id_pc4;
  logic [31:0] m_instr;
  logic        m_fault;
  logic [15:0] m_target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign m_target = redirect_pc;
`else
  assign m_target = {redirect_pc[15:2], 2'b00};
`endif

  function automatic logic bad_pc(input logic [15:0] pc);
`ifdef FETCH_ALIGN_CHECK_EN
    return (pc >= 16'h0200) || (pc % 4 != 0);
`else
    return pc >= 16'h0200;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_pc <= 16'h0000; m_valid <= 1'b0; m_id_pc <= 16'h0000;
      m_id_pc4 <= 16'h0000; m_instr <= NOP; m_fault <= 1'b0;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (redirect_valid) begin
      m_mode <= 1; m_pc <= m_target;
      m_valid <= 1'b0; m_instr <= NOP; m_fault <= 1'b0;
    end else if (m_mode == 2 || halt_req) begin
      m_mode <= 2;
      m_valid <= 1'b0; m_instr <= NOP; m_fault <= 1'b0;
    end else if (!stall) begin
      m_id_pc  <= m_pc;
      m_id_pc4 <= m_pc + 16'd4;
      m_pc     <= m_pc + 16'd4;
      if (bad_pc(m_pc)) begin
        m_valid <= 1'b0; m_instr <= NOP; m_fault <= 1'b1;
      end else begin
        m_valid <= 1'b1; m_instr <= rom[m_pc / 4]; m_fault <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_addr",   {16'h0, imem_addr},   {16'h0, m_pc});
    chk("id_valid",    {31'h0, id_valid},    {31'h0, m_valid});
    chk("id_pc",       {16'h0, id_pc},       {16'h0, m_id_pc});
    chk("id_pc_plus4", {16'h0, id_pc_plus4}, {16'h0, m_id_pc4});
    chk("id_instr",    id_instr,             m_instr);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
    chk("halted",      {31'h0, halted},      {31'h0, (m_mode == 2)});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redir(input logic [15:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h10000000 + 32'(i) * 32'h0101;
    #1 rst = 1'b1;
    tick(2);
    chk("rst_pc",    {16'h0, imem_addr}, 32'h0);
    chk("rst_valid", {31'h0, id_valid},  32'h0);
    chk("rst_instr", id_instr,           32'h00000013);
    chk("rst_halt",  {31'h0, halted},    32'h0);
    rst = 1'b0;
    tick(1);
    chk("boot_novalid", {31'h0, id_valid}, 32'h0);
    tick(1);
    chk("first_pc",    {16'h0, id_pc}, 32'h0);
    chk("first_instr", id_instr,       32'h10000000);
    tick(9);
    chk("seq10_pc",  {16'h0, id_pc},       32'd36);
    chk("seq10_pc4", {16'h0, id_pc_plus4}, 32'd40);

    // Reset pulse mid-run takes effect immediately.
    rst = 1'b1;
    #1;
    chk("midrst_pc",    {16'h0, imem_addr}, 32'h0);
    chk("midrst_valid", {31'h0, id_valid},  32'h0);
    chk("midrst_instr", id_instr,           32'h00000013);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("midrst_boot", {31'h0, id_valid}, 32'h0);
    tick(2);

    // Stall at pc=8 for three cycles.
    stall = 1'b1;
    tick(3);
    chk("stall_idpc", {16'h0, id_pc},     32'h4);
    chk("stall_pc",   {16'h0, imem_addr}, 32'h8);
    stall = 1'b0;
    tick(1);
    chk("resume_idpc",  {16'h0, id_pc}, 32'h8);
    chk("resume_instr", id_instr,       32'h10000202);

    // Redirect while stalled squashes the IF/ID word.
    stall = 1'b1;
    redir(16'h0028);
    stall = 1'b0;
    chk("rs_valid", {31'h0, id_valid},  32'h0);
    chk("rs_pc",    {16'h0, imem_addr}, 32'h28);
    tick(1);
    chk("rs_idpc", {16'h0, id_pc},    32'h28);
    chk("rs_vld2", {31'h0, id_valid}, 32'h1);

    // Last in-range word, then out of range.
    redir(16'h01FC);
    tick(1);
    chk("last_valid", {31'h0, id_valid}, 32'h1);
    chk("last_instr", id_instr,          32'h10007F7F);
    tick(1);
    chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
    chk("oor_idpc",  {16'h0, id_pc},       32'h200);
    chk("oor_pc",    {16'h0, imem_addr},   32'h204);

    // Halt, sit idle, resume via redirect.
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("halt_on",    {31'h0, halted},      32'h1);
    chk("halt_fault", {31'h0, fetch_fault}, 32'h0);
    tick(3);
    chk("halt_pchold", {16'h0, imem_addr}, 32'h204);
    redir(16'h0028);
    chk("halt_off", {31'h0, halted}, 32'h0);
    tick(1);
    chk("halt_res", {16'h0, id_pc}, 32'h28);

    // Halt while stalled; resume with misaligned target.
    stall = 1'b1; halt_req = 1'b1;
    tick(1);
    stall = 1'b0; halt_req = 1'b0;
    chk("hs_halt",  {31'h0, halted},   32'h1);
    chk("hs_valid", {31'h0, id_valid}, 32'h0);
    redir(16'h0006);
    tick(1);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", {31'h0, fetch_fault}, 32'h1);
`else
    chk("align_idpc",  {16'h0, id_pc},    32'h4);
    chk("align_valid", {31'h0, id_valid}, 32'h1);
`endif

    // Redirect beats a simultaneous halt request.
    halt_req = 1'b1;
    redir(16'h0010);
    halt_req = 1'b0;
    chk("rh_nohalt", {31'h0, halted},    32'h0);
    chk("rh_pc",     {16'h0, imem_addr}, 32'h10);
    tick(2);

    // PC wrap at the top of the 16-bit space.
    redir(16'hFFFC);
    tick(1);
    chk("wrap_fault", {31'h0, fetch_fault}, 32'h1);
    chk("wrap_pc4",   {16'h0, id_pc_plus4}, 32'h0);
    chk("wrap_pc",    {16'h0, imem_addr},   32'h0);
    tick(1);
    chk("wrap_valid", {31'h0, id_valid}, 32'h1);
    chk("wrap_instr", id_instr,          32'h10000000);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
